// File: rtl/msk_pkg.sv
// Shared definitions for the masked-data path: share layout, handshake FSM
// encoding and elaboration-time sizing helpers.
package msk_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } msk_state_e;

  // Flat bit index of share j of logical bit i in a d-share masked vector.
  function automatic int unsigned bit_share_idx(input int unsigned i,
                                                input int unsigned j,
                                                input int unsigned d);
    return i * d + j;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    if (v > 1) begin
      for (int unsigned x = v - 1; x != 0; x = x >> 1) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

  // A beat counter needs at least one bit even for single-beat words.
  function automatic int unsigned cnt_width(input int unsigned nbeat);
    return (clog2(nbeat) < 1) ? 1 : clog2(nbeat);
  endfunction

endpackage

// File: rtl/msk_shift_buf.sv
// Masked word buffer with load / clear / shift-right-by-S controls.
// Shares only move between flops or get zeroed; they are never combined.
module msk_shift_buf
  import msk_pkg::*;
#(
  parameter int unsigned W = 256,
  parameter int unsigned S = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic [S-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] shifted;

  if (S == 0 || S > W) begin : g_bad_cfg
    $error("msk_shift_buf: step S must be in 1..W");
  end

  // A full-width step leaves nothing behind: the shift result is all zeros.
  if (S >= W) begin : g_full_step
    assign shifted = '0;
  end else begin : g_part_step
    assign shifted = q_q >> S;
  end

  // Priority: load > clear > shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = data_i;
    end else if (clear_i) begin
      q_d = '0;
    end else if (shift_i) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q[S-1:0];

endmodule

// File: rtl/msk_chunk_serializer.sv
// Serialises one masked word (count bits x d shares) into count/chunk masked
// chunks, LSB chunk first, over valid/ready with back-to-back word support.
module msk_chunk_serializer
  import msk_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 128,
  parameter int unsigned chunk = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [count*d-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [chunk*d-1:0]   out_data,
  output logic                 out_last
);

  localparam int unsigned IN_W  = bit_share_idx(count, 0, d);
  localparam int unsigned OUT_W = bit_share_idx(chunk, 0, d);
  localparam int unsigned NBEAT = count / chunk;
  localparam int unsigned CW    = cnt_width(NBEAT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);

  if (d < 1) begin : g_bad_shares
    $error("msk_chunk_serializer: d must be >= 1");
  end
  if (chunk == 0 || count == 0 || (count % chunk) != 0) begin : g_bad_chunk
    $error("msk_chunk_serializer: count must be a non-zero multiple of chunk");
  end

  msk_state_e    state_q;
  msk_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic load;
  logic beat_acc;
  logic last_acc;
  logic buf_load;
  logic buf_clear;
  logic buf_shift;

  assign load     = in_valid & in_ready;
  assign beat_acc = out_valid & out_ready;
  assign last_acc = beat_acc & out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load always wins, which lets a new word replace the final beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    if (load) begin
      state_d  = ST_SEND;
      cnt_d    = '0;
      buf_load = 1'b1;
    end else if (last_acc) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      buf_clear = 1'b1;
    end else if (beat_acc) begin
      cnt_d     = cnt_q + CW'(1);
      buf_shift = 1'b1;
    end
  end

  always_comb begin
    out_valid = (state_q == ST_SEND);
    out_last  = (state_q == ST_SEND) & (cnt_q == LAST_BEAT);
    in_ready  = (state_q == ST_IDLE) | (out_valid & out_ready & out_last);
  end

  // The low chunk of the buffer flops is the output; no logic on the share lanes.
  msk_shift_buf #(
    .W (IN_W),
    .S (OUT_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .shift_i (buf_shift),
    .data_i  (in_data),
    .q_o     (out_data)
  );

endmodule

// File: tb/tb_msk_chunk_serializer.sv
// Bench for msk_chunk_serializer: a beat-queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_msk_chunk_serializer;

  localparam int unsigned D     = 2;
  localparam int unsigned COUNT = 128;
  localparam int unsigned CHUNK = 32;
  localparam int unsigned NBEAT = COUNT / CHUNK;
  localparam int unsigned IW    = COUNT * D;
  localparam int unsigned OW    = CHUNK * D;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;

  int n_vec = 0;
  int n_err = 0;

  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  msk_chunk_serializer #(
    .d     (D),
    .count (COUNT),
    .chunk (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word becomes NBEAT queued chunks; the head is the visible beat.
  always @(negedge clk) begin : model_check
    logic exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last",  128'(out_last),  128'(0));
      chk("rst_out_data",  128'(out_data),  128'(0));
      chk("rst_in_ready",  128'(in_ready),  128'(1));
    end else begin
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      chk("m_out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      chk("m_out_data",  128'(out_data),  (exp_q.size() != 0) ? 128'(exp_q[0]) : 128'(0));
      chk("m_out_last",  128'(out_last),  128'(exp_q.size() == 1));
      chk("m_in_ready",  128'(in_ready),  128'(exp_rdy));
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        for (int k = 0; k < int'(NBEAT); k++) exp_q.push_back(in_data[k*OW +: OW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the word is taken; leaves us one cycle after the load.
  task automatic load_word(input logic [IW-1:0] w);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
    chk("load_accepted", 128'(ok), 128'(1));
  endtask

  logic [63:0]   wa[4];
  logic [63:0]   wb[4];
  logic [IW-1:0] word_a;
  logic [IW-1:0] word_b;
  logic [127:0]  ct;
  logic [127:0]  rec;
  logic [IW-1:0] shw;
  logic [OW-1:0] beat;
  logic          s0;

  initial begin
    wa[0] = 64'h0123_4567_89AB_CDEF;
    wa[1] = 64'h1111_2222_3333_4444;
    wa[2] = 64'hAAAA_BBBB_CCCC_DDDD;
    wa[3] = 64'hFEDC_BA98_7654_3210;
    word_a = {wa[3], wa[2], wa[1], wa[0]};
    word_b = {wa[0], wa[1], wa[2], wa[3]};
    wb[0] = 64'hFEDC_BA98_7654_3210;
    wb[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    wb[2] = 64'h1111_2222_3333_4444;
    wb[3] = 64'h0123_4567_89AB_CDEF;

    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // 1: four beats at full rate, LSB chunk first, then idle with zeroed data.
    load_word(word_a);
    for (int k = 0; k < 4; k++) begin
      chk("t1_data",  128'(out_data),  128'(wa[k]));
      chk("t1_last",  128'(out_last),  128'(k == 3));
      chk("t1_valid", 128'(out_valid), 128'(1));
      tick();
    end
    chk("t1_idle_valid", 128'(out_valid), 128'(0));
    chk("t1_idle_data",  128'(out_data),  128'(0));
    chk("t1_idle_ready", 128'(in_ready),  128'(1));
    tick();

    // 2: backpressure during beat 2 holds the chunk.
    load_word(word_a);
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t2_hold_data",  128'(out_data),  128'(wa[1]));
      chk("t2_hold_valid", 128'(out_valid), 128'(1));
      tick();
    end
    out_ready = 1'b1;
    chk("t2_resume", 128'(out_data), 128'(wa[1]));
    tick();
    chk("t2_beat3", 128'(out_data), 128'(wa[2]));
    tick();
    chk("t2_beat4", 128'(out_data), 128'(wa[3]));
    tick();
    chk("t2_idle", 128'(out_valid), 128'(0));
    tick();

    // 3: two words back to back with in_valid held high.
    in_valid = 1'b1;
    in_data  = word_a;
    tick();
    in_data  = word_b;
    for (int b = 0; b < 8; b++) begin
      chk("t3_valid", 128'(out_valid), 128'(1));
      chk("t3_data",  128'(out_data),  (b < 4) ? 128'(wa[b]) : 128'(wb[b-4]));
      chk("t3_ready", 128'(in_ready),  128'(b % 4 == 3));
      tick();
      if (b == 3) in_valid = 1'b0;
    end
    chk("t3_idle", 128'(out_valid), 128'(0));
    tick();

    // 4: a word offered mid-transfer is refused.
    load_word(word_a);
    tick();
    in_valid = 1'b1;
    in_data  = word_b;
    chk("t4_refuse", 128'(in_ready), 128'(0));
    tick();
    in_valid = 1'b0;
    chk("t4_beat3", 128'(out_data), 128'(wa[2]));
    tick();
    chk("t4_beat4", 128'(out_data), 128'(wa[3]));
    tick();
    chk("t4_idle", 128'(out_valid), 128'(0));
    tick();

    // 5: asynchronous reset during beat 3, then a fresh word.
    load_word(word_a);
    tick();
    tick();
    chk("t5_pre", 128'(out_data), 128'(wa[2]));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_last",  128'(out_last),  128'(0));
    chk("t5_rst_data",  128'(out_data),  128'(0));
    chk("t5_rst_ready", 128'(in_ready),  128'(1));
    tick();
    rst_n = 1'b1;
    tick();
    load_word(word_a);
    chk("t5_restart", 128'(out_data), 128'(wa[0]));
    for (int k = 0; k < 4; k++) tick();
    chk("t5_idle", 128'(out_valid), 128'(0));

    // 6: random share pairs reconstruct the ciphertext.
    ct = 128'h3925841D02DC09FBDC118597196A0B32;
    for (int i = 0; i < 128; i++) begin
      s0 = 1'($urandom);
      shw[2*i]   = s0;
      shw[2*i+1] = s0 ^ ct[i];
    end
    load_word(shw);
    rec = '0;
    for (int k = 0; k < 4; k++) begin
      beat = out_data;
      for (int j = 0; j < 32; j++) rec[k*32+j] = beat[2*j] ^ beat[2*j+1];
      tick();
    end
    chk("t6_cipher", rec, ct);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
